alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the execute stage and a future address/branch helper.
- Each request has a valid/ready handshake; grant is round-robin; the result is registered on one shared response channel tagged with the source.
- Instantiates the existing ALU internally; one result register, so throughput is 1 op/cycle when the response is drained every cycle.

Parameters:
- WORD_W, 32, operand/result width; matches rvga_word.
- ALUOP_W, 4, width of the aluop encoding; matches rvga_aluop.
- CNT_W, 32, width of the accepted-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle (combinational).
- req0_a  in  WORD_W  operand a, requester 0.
- req0_b  in  WORD_W  operand b, requester 0.
- req0_op  in  ALUOP_W  aluop, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above for requester 1.
- resp_valid  out  1  registered result available.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  WORD_W  registered ALU result.
- resp_src  out  1  requester that issued the op in resp_data.
- op_count  out  CNT_W  number of accepted ops.

Behaviour:
- Reset (async, immediate): resp_valid=0, resp_data=0, resp_src=0, op_count=0, last_grant=1 (so requester 0 wins the first tie).
- req*_ready depend only on state and the valids; the outputs have no combinational path from operand or op inputs.
- can_accept = !resp_valid || resp_ready (result register empty or draining this cycle).
- Grant selection:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester != last_grant.
  - Neither valid: no grant.
- reqN_ready = can_accept && grant==N; at most one ready is high per cycle.
- Accept = reqN_valid && reqN_ready. On an accept edge:
  - ALU evaluates the granted operands/op; resp_data <= f, resp_src <= N, resp_valid <= 1.
  - last_grant <= N.
  - op_count <= op_count+1, wrapping mod 2^CNT_W.
- Latency: accepted at edge k, resp_valid high after edge k and stays high until resp_ready is sampled high.
- Response held: while resp_valid && !resp_ready, resp_data and resp_src are stable, both readys are 0, and last_grant is unchanged.
- Simultaneous drain and accept: when resp_ready=1 with resp_valid=1 and a new accept happens, the register loads the new result and resp_valid stays 1. This gives back-to-back 1 op/cycle.
- Drain without accept: resp_valid <= 0; resp_data and resp_src keep their old values.
- Requesters must hold valid/operands stable until ready. A deasserted valid with no accept loses nothing and does not change last_grant.
- ALU semantics are unchanged, including an unknown aluop producing 0; the arbiter passes aluop through untouched.
- Reset mid-operation: any pending result is discarded, resp_valid=0, and the round-robin pointer returns to the reset state.
- State summary, two states:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on hold, or on drain with accept.

Test Plan:
- Reset then req0 only: req0 add a=5,b=7, resp_ready=1 → req0_ready=1 in that cycle; next cycle resp_valid=1, resp_data=12, resp_src=0, op_count=1.
- Both valid every cycle, resp_ready=1:
  - req0 passa a=0xA, req1 passb b=0xB → grants alternate 0,1,0,1 starting with 0.
  - resp_data sequence 0xA,0xB,0xA,0xB; resp_src sequence 0,1,0,1; one result per cycle.
- Backpressure: accept req1 sub a=3,b=5, hold resp_ready=0 for 4 cycles with req0 valid → resp_data=0xFFFFFFFE held stable, req0_ready=0 throughout; when resp_ready rises, req0 is accepted in the same cycle.
- Ops through arbiter:
  - req1 sra a=0x80000000,b=4 → 0xF8000000.
  - req0 sltu a=1,b=0xFFFFFFFF → 1.
  - req0 unknown op → 0.
- Async reset while resp_valid=1 and both requesters valid → resp_valid drops immediately without a clock edge, op_count=0; the first grant after release goes to req0.
- Counter wrap with CNT_W=4: 17 accepts → op_count=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// valid/ready requesters, with a single registered, source-tagged response.
// Also holds rvga_alu, the shared combinational ALU the arbiter wraps.

module rvga_alu #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic [WORD_W-1:0]  a,
    input  logic [WORD_W-1:0]  b,
    input  logic [ALUOP_W-1:0] op,
    output logic [WORD_W-1:0]  y
);

    localparam int unsigned SHW = $clog2(WORD_W);

    localparam logic [ALUOP_W-1:0] OP_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] OP_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_SLL   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_SLT   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_SLTU  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] OP_XOR   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OP_SRL   = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] OP_SRA   = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] OP_AND   = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] OP_PASSA = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] OP_PASSB = ALUOP_W'(11);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    // Operation decode; any unlisted encoding yields zero.
    always_comb begin
        y = '0;
        unique case (op)
            OP_ADD:   y = a + b;
            OP_SUB:   y = a - b;
            OP_SLL:   y = a << shamt;
            OP_SLT:   y[0] = ($signed(a) < $signed(b));
            OP_SLTU:  y[0] = (a < b);
            OP_XOR:   y = a ^ b;
            OP_SRL:   y = a >> shamt;
            OP_SRA:   y = $signed(a) >>> shamt;
            OP_OR:    y = a | b;
            OP_AND:   y = a & b;
            OP_PASSA: y = a;
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end

endmodule

module alu_arbiter #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WORD_W-1:0]  req0_a,
    input  logic [WORD_W-1:0]  req0_b,
    input  logic [ALUOP_W-1:0] req0_op,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WORD_W-1:0]  req1_a,
    input  logic [WORD_W-1:0]  req1_b,
    input  logic [ALUOP_W-1:0] req1_op,

    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WORD_W-1:0]  resp_data,
    output logic               resp_src,

    output logic [CNT_W-1:0]   op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                last_grant;
    logic                grant_vld;
    logic                grant_sel;
    logic                can_accept;
    logic                accept;
    logic [WORD_W-1:0]   alu_a;
    logic [WORD_W-1:0]   alu_b;
    logic [ALUOP_W-1:0]  alu_op;
    logic [WORD_W-1:0]   alu_y;

    // Round-robin grant, ready generation and next-state; depends only on
    // state and the valids, never on operands.
    always_comb begin
        grant_vld  = 1'b0;
        grant_sel  = 1'b0;
        can_accept = 1'b0;
        accept     = 1'b0;
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case ({req1_valid, req0_valid})
            2'b01:   begin grant_vld = 1'b1; grant_sel = 1'b0;        end
            2'b10:   begin grant_vld = 1'b1; grant_sel = 1'b1;        end
            2'b11:   begin grant_vld = 1'b1; grant_sel = ~last_grant; end
            default: begin grant_vld = 1'b0; grant_sel = 1'b0;        end
        endcase

        can_accept = (state == EMPTY) || resp_ready;
        accept     = can_accept && grant_vld;
        req0_ready = accept && !grant_sel;
        req1_ready = accept &&  grant_sel;

        case (state)
            EMPTY:   if (accept) state_nx = FULL;
            FULL:    if (resp_ready && !accept) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    assign alu_a  = grant_sel ? req1_a  : req0_a;
    assign alu_b  = grant_sel ? req1_b  : req0_b;
    assign alu_op = grant_sel ? req1_op : req0_op;

    rvga_alu #(
        .WORD_W  (WORD_W),
        .ALUOP_W (ALUOP_W)
    ) u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    // State register plus result, source tag, round-robin pointer and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            resp_data  <= '0;
            resp_src   <= 1'b0;
            last_grant <= 1'b1;
            op_count   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                resp_data  <= alu_y;
                resp_src   <= grant_sel;
                last_grant <= grant_sel;
                op_count   <= op_count + CNT_W'(1);
            end
        end
    end

    assign resp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table of single-op vectors plus
// hand-written sequences for round-robin, backpressure, async reset and
// counter wrap. Counter width is reduced to 4 bits to reach the wrap.

module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_PASSA = 4'd10;
    localparam logic [3:0] OP_PASSB = 4'd11;
    localparam logic [3:0] OP_BAD   = 4'd15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_op;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_src;
    logic [3:0]  op_count;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(
        .WORD_W  (32),
        .ALUOP_W (4),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_src   (resp_src),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  op0;
        logic        v1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [3:0]  op1;
        logic        er0;
        logic        er1;
        logic        erv;
        logic [31:0] edata;
        logic        esrc;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_cnt;

        // vectors: requester 0, requester 1, expected readies, expected response
        tbl[0] = '{1'b0, 32'h0, 32'h0, OP_ADD,
                   1'b1, 32'h8000_0000, 32'd4, OP_SRA,
                   1'b0, 1'b1, 1'b1, 32'hF800_0000, 1'b1};
        tbl[1] = '{1'b1, 32'd1, 32'hFFFF_FFFF, OP_SLTU,
                   1'b0, 32'h0, 32'h0, OP_ADD,
                   1'b1, 1'b0, 1'b1, 32'd1, 1'b0};
        tbl[2] = '{1'b1, 32'd5, 32'd9, OP_BAD,
                   1'b0, 32'h0, 32'h0, OP_ADD,
                   1'b1, 1'b0, 1'b1, 32'd0, 1'b0};
        tbl[3] = '{1'b1, 32'd2, 32'd3, OP_ADD,
                   1'b1, 32'hF0, 32'hFF, OP_XOR,
                   1'b0, 1'b1, 1'b1, 32'h0F, 1'b1};
        tbl[4] = '{1'b1, 32'd2, 32'd3, OP_ADD,
                   1'b1, 32'hF0, 32'hFF, OP_XOR,
                   1'b1, 1'b0, 1'b1, 32'd5, 1'b0};
        tbl[5] = '{1'b0, 32'h0, 32'h0, OP_ADD,
                   1'b0, 32'h0, 32'h0, OP_ADD,
                   1'b0, 1'b0, 1'b0, 32'd5, 1'b0};
        tbl[6] = '{1'b0, 32'h0, 32'h0, OP_ADD,
                   1'b1, 32'd1, 32'd31, OP_SLL,
                   1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1};
        tbl[7] = '{1'b1, 32'hFF00_FF00, 32'h0FF0_0FF0, OP_AND,
                   1'b0, 32'h0, 32'h0, OP_ADD,
                   1'b1, 1'b0, 1'b1, 32'h0F00_0F00, 1'b0};
        tbl[8] = '{1'b0, 32'h0, 32'h0, OP_ADD,
                   1'b1, 32'hFFFF_FFFF, 32'd1, OP_SLT,
                   1'b0, 1'b1, 1'b1, 32'd1, 1'b1};
        tbl[9] = '{1'b0, 32'h0, 32'h0, OP_ADD,
                   1'b1, 32'h8000_0000, 32'd4, OP_SRL,
                   1'b0, 1'b1, 1'b1, 32'h0800_0000, 1'b1};

        // ---- reset state ----
        do_reset();
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_data", resp_data, 32'd0);
        chk("reset resp_src", 32'(resp_src), 32'd0);
        chk("reset op_count", 32'(op_count), 32'd0);
        #1;
        chk("idle req0_ready", 32'(req0_ready), 32'd0);
        chk("idle req1_ready", 32'(req1_ready), 32'd0);

        // ---- req0 add 5+7 ----
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = OP_ADD;
        resp_ready = 1'b1;
        #1;
        chk("add req0_ready", 32'(req0_ready), 32'd1);
        chk("add req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("add resp_valid", 32'(resp_valid), 32'd1);
        chk("add resp_data", resp_data, 32'd12);
        chk("add resp_src", 32'(resp_src), 32'd0);
        chk("add op_count", 32'(op_count), 32'd1);

        // ---- round-robin alternation with both valid ----
        do_reset();
        req0_valid = 1'b1; req0_a = 32'hA; req0_b = 32'h0; req0_op = OP_PASSA;
        req1_valid = 1'b1; req1_a = 32'h0; req1_b = 32'hB; req1_op = OP_PASSB;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr req0_ready", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr req1_ready", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("rr resp_valid", 32'(resp_valid), 32'd1);
            chk("rr resp_data", resp_data, (i % 2 == 0) ? 32'hA : 32'hB);
            chk("rr resp_src", 32'(resp_src), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr op_count", 32'(op_count), 32'(i + 1));
        end

        // ---- backpressure ----
        do_reset();
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd5; req1_op = OP_SUB;
        resp_ready = 1'b1;
        tick();
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = OP_ADD;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp req0_ready", 32'(req0_ready), 32'd0);
            chk("bp req1_ready", 32'(req1_ready), 32'd0);
            chk("bp resp_valid", 32'(resp_valid), 32'd1);
            chk("bp resp_data", resp_data, 32'hFFFF_FFFE);
            chk("bp resp_src", 32'(resp_src), 32'd1);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp release req0_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("bp release resp_valid", 32'(resp_valid), 32'd1);
        chk("bp release resp_data", resp_data, 32'd3);
        chk("bp release resp_src", 32'(resp_src), 32'd0);
        chk("bp release op_count", 32'(op_count), 32'd2);
        tick();
        chk("bp drain resp_valid", 32'(resp_valid), 32'd0);
        chk("bp drain resp_data", resp_data, 32'd3);

        // ---- table-driven ops ----
        do_reset();
        exp_cnt = 4'd0;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req0_valid = tbl[i].v0; req0_a = tbl[i].a0; req0_b = tbl[i].b0; req0_op = tbl[i].op0;
            req1_valid = tbl[i].v1; req1_a = tbl[i].a1; req1_b = tbl[i].b1; req1_op = tbl[i].op1;
            #1;
            chk($sformatf("vec%0d req0_ready", i), 32'(req0_ready), 32'(tbl[i].er0));
            chk($sformatf("vec%0d req1_ready", i), 32'(req1_ready), 32'(tbl[i].er1));
            if (tbl[i].er0 || tbl[i].er1) exp_cnt = exp_cnt + 4'd1;
            tick();
            chk($sformatf("vec%0d resp_valid", i), 32'(resp_valid), 32'(tbl[i].erv));
            chk($sformatf("vec%0d resp_data", i), resp_data, tbl[i].edata);
            chk($sformatf("vec%0d resp_src", i), 32'(resp_src), 32'(tbl[i].esrc));
            chk($sformatf("vec%0d op_count", i), 32'(op_count), 32'(exp_cnt));
        end

        // ---- async reset while full with both requesters valid ----
        idle_inputs();
        req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4; req0_op = OP_ADD;
        tick();
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = OP_ADD;
        tick();
        chk("arst pre resp_valid", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst resp_valid", 32'(resp_valid), 32'd0);
        chk("arst op_count", 32'(op_count), 32'd0);
        chk("arst resp_data", resp_data, 32'd0);
        #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("arst first req0_ready", 32'(req0_ready), 32'd1);
        chk("arst first req1_ready", 32'(req1_ready), 32'd0);
        tick();
        chk("arst first resp_src", 32'(resp_src), 32'd0);
        chk("arst first resp_data", resp_data, 32'd8);

        // ---- counter wrap (4-bit) ----
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = OP_ADD;
        resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("wrap op_count 16", 32'(op_count), 32'd0);
        tick();
        chk("wrap op_count 17", 32'(op_count), 32'd1);
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
